// File: rtl/m_timer_sched_pkg.sv
// Shared encodings for the millisecond timer scheduler: arbiter states and
// channel counting modes.
package m_timer_sched_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/m_timer_chan.sv
// One countdown channel: counter, mode, busy, pending-event and sticky
// overrun state, advanced by the shared millisecond tick.
module m_timer_chan
  import m_timer_sched_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          stop,
  input  logic          mode_in,
  input  logic [CW-1:0] period_in,
  input  logic          tick,
  input  logic          ack_clr,
  output logic          busy,
  output logic          pending,
  output logic          ovf
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  logic          mode;
  logic          expire;

  // A config in the same cycle suppresses the tick, so expiry never races a reload.
  assign expire = tick && busy && !load && !stop && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; every state bit, including
    // the counter and stored period, gets a defined value here.
    if (!rst_n) begin
      cnt     <= '0;
      period  <= '0;
      mode    <= MODE_ONESHOT;
      busy    <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of cnt/busy/pending regardless of statement order.
      if (load) begin
        cnt    <= period_in;
        period <= period_in;
        mode   <= mode_in;
        busy   <= 1'b1;
      end else if (stop) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else if (tick && busy) begin
        if (cnt == CW'(1)) begin
          if (mode == MODE_PERIODIC) begin
            cnt <= period;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end

      // A new expiry outranks an ack landing in the same cycle.
      if (expire)       pending <= 1'b1;
      else if (ack_clr) pending <= 1'b0;

      if (load || stop)                       ovf <= 1'b0;
      else if (expire && pending && !ack_clr) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/m_timer_sched.sv
// Multi-channel millisecond timer: config decode, NCH countdown channels and
// a round-robin arbiter presenting one expiry event at a time.
module m_timer_sched
  import m_timer_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic                   cfg_en,
  input  logic                   cfg_mode,
  input  logic [CW-1:0]          cfg_period,
  output logic                   evt_valid,
  output logic [$clog2(NCH)-1:0] evt_ch,
  input  logic                   evt_ack,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         ovf
);

  localparam int CHW = $clog2(NCH);

  arb_state_t     state;
  logic [CHW-1:0] last;
  logic [CHW-1:0] pick;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] ack_clr;
  logic [NCH-1:0] load;
  logic [NCH-1:0] stop;
  logic           accept;
  logic           zero_period;

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_ready <= 1'b0;
    else        cfg_ready <= 1'b1;
  end

  assign accept      = cfg_valid && cfg_ready;
  assign zero_period = (cfg_period == '0);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign load[i] = accept && (cfg_ch == CHW'(i)) && cfg_en && !zero_period;
    assign stop[i] = accept && (cfg_ch == CHW'(i)) && (!cfg_en || zero_period);

    m_timer_chan #(.CW(CW)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .stop      (stop[i]),
      .mode_in   (cfg_mode),
      .period_in (cfg_period),
      .tick      (tick_in),
      .ack_clr   (ack_clr[i]),
      .busy      (busy[i]),
      .pending   (pending[i]),
      .ovf       (ovf[i])
    );
  end

  // Scan last+1, last+2, ... modulo NCH; the sum is one bit wider so the
  // wrap works for non-power-of-two channel counts.
  always_comb begin
    logic [CHW:0] s;
    logic         found;
    // NOTE: defaults before the loop keep this purely combinational.
    pick  = '0;
    found = 1'b0;
    s     = '0;
    for (int i = 1; i <= NCH; i++) begin
      s = {1'b0, last} + (CHW+1)'(i);
      if (s >= (CHW+1)'(NCH)) s = s - (CHW+1)'(NCH);
      if (!found && pending[s[CHW-1:0]]) begin
        pick  = s[CHW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (state == ARB_PRESENT && evt_ack) ack_clr[evt_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      last      <= CHW'(NCH - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|pending) begin
            state     <= ARB_PRESENT;
            evt_valid <= 1'b1;
            evt_ch    <= pick;
          end
        end
        ARB_PRESENT: begin
          if (evt_ack) begin
            state     <= ARB_IDLE;
            evt_valid <= 1'b0;
            last      <= evt_ch;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
